srrc_sym_fir_param: RTL
=======================

Name: srrc_sym_fir_param

Overview:
- Parametrised, fully pipelined, symmetric (linear-phase) odd-length FIR for the pulse-shaping path (SRRC TX/RX).
- Successor to the fixed 121-tap SRRC filter. Adds generic tap count and widths, full-precision internal arithmetic, and convergent-free round-half-up output scaling.
- Adds runtime-reloadable double-buffered coefficients with a glitch-free bank swap, and an output-valid strobe.
- Sits between the symbol mapper/upsampler and the DAC/channel model, in the sam_clk_en domain of clk.

Parameters:
- DATA_W, 18, input/output sample width (signed).
- COEF_W, 18, coefficient width (signed).
- NTAPS, 121, filter length; must be odd and ≥3. NH=(NTAPS+1)/2 unique coefficients.
- OUT_SHIFT, 17, right shift applied to the full-precision accumulator before output.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sam_clk_en  in  1  sample strobe; one new input sample per high cycle.
- in  in  DATA_W  signed input sample, captured when sam_clk_en=1.
- out  out  DATA_W  signed filtered sample.
- out_valid  out  1  one-cycle pulse when out updates.
- coef_wr_en  in  1  write strobe to shadow coefficient bank.
- coef_wr_addr  in  clog2(NH)  shadow index; 0 = outer tap pair, NH-1 = centre tap.
- coef_wr_data  in  COEF_W  signed coefficient value.
- coef_swap  in  1  request to load shadow bank into active bank.
- coef_busy  out  1  high while a swap is pending or completing.

Behaviour:
- Reset: clears delay line, all pipeline registers, valid pipe, both coefficient banks, and FSM (IDLE). out=0, out_valid=0, coef_busy=0.
- Delay line x[0..NTAPS-1] shifts only on sam_clk_en: x[0]<=in. Strobe at edge t.
- Stage 1, pre-add, every clk (edge t+1):
  - p[i]=x[i]+x[NTAPS-1-i] for i<NH-1; p[NH-1]=x[NH-1].
  - Width DATA_W+1, sign-extended, no truncation.
- Stage 2, multiply (edge t+2): m[i]=p[i]*active[i]. Width DATA_W+1+COEF_W.
- Stage 3, adder tree: L=clog2(NH) registered levels (edges t+3..t+2+L).
  - Odd element at a level passes through registered.
  - Full precision ACC_W=DATA_W+1+COEF_W+L; no intermediate truncation.
- Stage 4, output (edge t+3+L):
  - r=(acc+2^(OUT_SHIFT-1))>>>OUT_SHIFT; if OUT_SHIFT=0, no rounding add.
  - r is reduced to DATA_W (see Optional Feature).
  - out<=reduced r; out_valid<=1 for one cycle.
  - Total latency 3+L clks (9 for NTAPS=121).
- Valid pipe: sam_clk_en delayed 3+L clks drives out_valid. out holds its value when out_valid=0.
- Back-to-back sam_clk_en (every clk) is supported; one output per strobe, in order.
- Coefficient FSM:
  - IDLE: coef_wr_en writes shadow[coef_wr_addr]. A write with coef_wr_addr≥NH is ignored. coef_swap → PENDING.
  - PENDING: waits for the first edge with sam_clk_en=1, then → COPY.
  - COPY: active<=shadow (all NH) on this edge → IDLE.
  - coef_busy=1 in PENDING and COPY. coef_wr_en and coef_swap are ignored while coef_busy=1.
  - Swap boundary: the sample strobed at the PENDING→COPY edge, and all later samples, use the new bank. All earlier samples use the old bank, with no mixed-bank outputs.
  - coef_swap together with coef_wr_en in IDLE: the write lands first, and the swap includes it.
- Reset asserted mid-operation (including PENDING/COPY) returns everything to reset state on that edge. No out_valid pulses for samples that were in flight.

Optional Feature:
- Macro SRRC_FIR_SAT_EN.
- Defined: r is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: r is truncated to its low DATA_W bits (two's-complement wrap), matching the legacy filter behaviour.

Test Plan:
- Impulse, NTAPS=5, DATA_W=18, OUT_SHIFT=0, coefs [1,2,3] swapped in; in=1 then 0s at every-4th-clk strobes → out sequence 1,2,3,2,1,0. Each out_valid occurs 5 clks after its strobe (L=2).
- Back-to-back strobes, same config: constant in=100 for 10 clks → steady out=900 after ramp 100,300,600,800; one out_valid per clk.
- Swap boundary: continuous strobes with coefs [1,0,0], in=ramp 1,2,3...; write [0,0,1] and pulse coef_swap → coef_busy for exactly 2 clks. Outputs switch from x[n]+x[n-4] to x[n-2] exactly at the sample strobed on the PENDING→COPY edge.
- Rounding/scaling, OUT_SHIFT=2: centre coef 3, in=1 → out=1 ((3+2)>>2). in=-1 → out=-1 ((-3+2)>>2).
- Overflow, NTAPS=5, coefs [0,0,2], in=2^17-1:
  - With SRRC_FIR_SAT_EN → out=131071.
  - Without → out=-2 (wrap).
- Reset and ignore rules:
  - Assert reset 1 clk mid-stream and during PENDING → out=0, out_valid=0, coef_busy=0 next clk; active bank all-zero (zero output for nonzero input).
  - Write with coef_wr_addr=NH → no change to filter output.

Source files
------------

// File: rtl/srrc_sym_fir_param.sv
// Symmetric odd-length SRRC pulse-shaping FIR with double-buffered, runtime-swappable coefficients.
// Latency 3+clog2(NH) clk from the strobe edge to out/out_valid; one output per sam_clk_en strobe.
// No backpressure: accepts a sample every clk; optional output clamp via macro SRRC_FIR_SAT_EN.
module srrc_sym_fir_param #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NTAPS     = 121,
  parameter int OUT_SHIFT = 17
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sam_clk_en,
  input  logic signed [DATA_W-1:0]             in,
  output logic signed [DATA_W-1:0]             out,
  output logic                                 out_valid,
  input  logic                                 coef_wr_en,
  input  logic [$clog2((NTAPS+1)/2)-1:0]       coef_wr_addr,
  input  logic signed [COEF_W-1:0]             coef_wr_data,
  input  logic                                 coef_swap,
  output logic                                 coef_busy
);

  localparam int NH     = (NTAPS + 1) / 2;
  localparam int ADDR_W = $clog2(NH);
  localparam int L      = $clog2(NH);
  localparam int P_W    = DATA_W + 1;
  localparam int M_W    = P_W + COEF_W;
  localparam int ACC_W  = M_W + L;
  localparam int LAT    = 3 + L;
  localparam int RSH    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RSH) : (ACC_W+1)'(0);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PENDING, COPY} cstate_e;

  cstate_e                   state_q, state_d;
  logic                      shadow_we, bank_copy, addr_ok;
  logic signed [COEF_W-1:0]  shadow_q [NH];
  logic signed [COEF_W-1:0]  active_q [NH];
  logic signed [DATA_W-1:0]  x_q [NTAPS];
  logic signed [P_W-1:0]     p_q [NH];
  // Level 0 holds products; each further level halves the populated width.
  // Entries beyond the populated width stay zero, so an odd element simply
  // adds to zero and passes through registered.
  logic signed [ACC_W-1:0]   tree_q [L+1][2*NH];
  logic [LAT-1:0]            vld_q;
  logic                      out_valid_q;
  logic signed [DATA_W-1:0]  out_q, out_d;
  logic signed [ACC_W:0]     acc_x, r_d;

  assign addr_ok   = ({1'b0, coef_wr_addr} < (ADDR_W+1)'(NH));
  assign coef_busy = (state_q != IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

  // Coefficient bank FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: writes/swap requests only honoured in IDLE; copy waits for a sample strobe
  // so the bank changes exactly between two samples' multiply cycles.
  always_comb begin
    state_d   = state_q;
    shadow_we = 1'b0;
    bank_copy = 1'b0;
    case (state_q)
      IDLE: begin
        shadow_we = coef_wr_en && addr_ok;
        if (coef_swap) state_d = PENDING;
      end
      PENDING: if (sam_clk_en) state_d = COPY;
      COPY: begin
        bank_copy = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow bank takes writes; active bank reloads from shadow in one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (shadow_we) shadow_q[coef_wr_addr] <= coef_wr_data;
      if (bank_copy) active_q <= shadow_q;
    end
  end

  // Tap delay line advances only on a sample strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else if (sam_clk_en) begin
      x_q[0] <= in;
      for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  // Fold symmetric tap pairs; centre tap passes alone. One extra bit, no truncation.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NH; i++) begin
      if (reset)
        p_q[i] <= '0;
      else if (i == NH - 1)
        p_q[i] <= {x_q[i][DATA_W-1], x_q[i]};
      else
        p_q[i] <= {x_q[i][DATA_W-1], x_q[i]} + {x_q[NTAPS-1-i][DATA_W-1], x_q[NTAPS-1-i]};
    end
  end

  // Multiply by the active bank, then a registered full-precision pairwise adder tree.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= L; k++)
        for (int j = 0; j < 2*NH; j++) tree_q[k][j] <= '0;
    end else begin
      for (int j = 0; j < NH; j++)
        tree_q[0][j] <= ACC_W'(p_q[j]) * ACC_W'(active_q[j]);
      for (int j = NH; j < 2*NH; j++) tree_q[0][j] <= '0;
      for (int k = 1; k <= L; k++) begin
        for (int j = 0; j < NH; j++)
          tree_q[k][j] <= tree_q[k-1][2*j] + tree_q[k-1][2*j+1];
        for (int j = NH; j < 2*NH; j++) tree_q[k][j] <= '0;
      end
    end
  end

  // Round half up, scale, then reduce to the output width (clamp or wrap).
  always_comb begin
    acc_x = {tree_q[L][0][ACC_W-1], tree_q[L][0]};
    r_d   = (acc_x + RND) >>> OUT_SHIFT;
`ifdef SRRC_FIR_SAT_EN
    if (r_d > SAT_MAX)      out_d = SAT_MAX[DATA_W-1:0];
    else if (r_d < SAT_MIN) out_d = SAT_MIN[DATA_W-1:0];
    else                    out_d = r_d[DATA_W-1:0];
`else
    out_d = r_d[DATA_W-1:0];
`endif
  end

  // Valid pipe tracks each strobe through the datapath; out updates only with its pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      vld_q       <= {vld_q[LAT-2:0], sam_clk_en};
      out_valid_q <= vld_q[LAT-1];
      if (vld_q[LAT-1]) out_q <= out_d;
    end
  end

endmodule
